// File: rtl/piso_pkg.sv
// Shared types and width helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W = clog2_min1(DEFAULT_WIDTH);

endpackage

// File: rtl/sipo_shift.sv
// Right-shifting serial-in/parallel-out register; serial data enters at the MSB.
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] sipo_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sipo_out <= '0;
        else if (en)
            sipo_out <= {ser_in, sipo_out[WIDTH-1:1]};
    end

endmodule

// File: rtl/piso_serializer.sv
// Accepts a word over valid/ready and emits it LSB-first with shift enable,
// last strobe, downstream hold and an optional idle gap between words.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             par_valid,
    output logic             par_ready,
    input  logic             ser_hold,
    output logic             ser_out,
    output logic             ser_en,
    output logic             ser_last,
    output logic             busy
);

    localparam int CW = clog2_min1(WIDTH);
    localparam int GW = clog2_min1(GAP + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic             at_last;
    logic             accept;

    assign ser_en    = (state == SHIFT) && !ser_hold;
    assign at_last   = ser_en && (cnt == CNT_LAST);
    assign par_ready = (state == IDLE) || ((GAP == 0) && at_last);
    assign accept    = par_valid && par_ready;
    assign ser_out   = shreg[0];
    assign ser_last  = at_last;
    assign busy      = (state != IDLE);

    // The parameter GAP shadows the enum literal, so the gap state is package-qualified.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (at_last) begin
                    if (GAP > 0)
                        state_nxt = piso_pkg::GAP;
                    else if (!par_valid)
                        state_nxt = IDLE;
                end
            end
            piso_pkg::GAP: begin
                if (gcnt == GCNT_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= par_in;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // Entering the gap keeps shreg so ser_out keeps showing the final bit.
                    if (at_last && (GAP > 0)) begin
                        cnt  <= '0;
                        gcnt <= '0;
                    end else if (accept) begin
                        shreg <= par_in;
                        cnt   <= '0;
                    end else if (at_last) begin
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (ser_en) begin
                        shreg <= {1'b0, shreg[WIDTH-1:1]};
                        cnt   <= cnt + 1'b1;
                    end
                end
                piso_pkg::GAP: begin
                    if (gcnt == GCNT_LAST) begin
                        shreg <= '0;
                        gcnt  <= '0;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializers (GAP 0/1/2) each feeding a SIPO, shared stimulus.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] par_in;
    logic       par_valid;
    logic       ser_hold;

    logic       par_ready_0, ser_out_0, ser_en_0, ser_last_0, busy_0;
    logic       par_ready_1, ser_out_1, ser_en_1, ser_last_1, busy_1;
    logic       par_ready_2, ser_out_2, ser_en_2, ser_last_2, busy_2;
    logic [7:0] sipo_0, sipo_1, sipo_2;
    logic [4:0] st0, st1, st2;

    int checks;
    int errors;

    assign st0 = {ser_en_0, ser_out_0, ser_last_0, busy_0, par_ready_0};
    assign st1 = {ser_en_1, ser_out_1, ser_last_1, busy_1, par_ready_1};
    assign st2 = {ser_en_2, ser_out_2, ser_last_2, busy_2, par_ready_2};

    piso_serializer #(.WIDTH(8), .GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .par_in(par_in), .par_valid(par_valid),
        .par_ready(par_ready_0), .ser_hold(ser_hold), .ser_out(ser_out_0),
        .ser_en(ser_en_0), .ser_last(ser_last_0), .busy(busy_0));
    sipo_shift #(.WIDTH(8)) u_sipo0 (
        .clk(clk), .rst_n(rst_n), .en(ser_en_0), .ser_in(ser_out_0), .sipo_out(sipo_0));

    piso_serializer #(.WIDTH(8), .GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .par_in(par_in), .par_valid(par_valid),
        .par_ready(par_ready_1), .ser_hold(ser_hold), .ser_out(ser_out_1),
        .ser_en(ser_en_1), .ser_last(ser_last_1), .busy(busy_1));
    sipo_shift #(.WIDTH(8)) u_sipo1 (
        .clk(clk), .rst_n(rst_n), .en(ser_en_1), .ser_in(ser_out_1), .sipo_out(sipo_1));

    piso_serializer #(.WIDTH(8), .GAP(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .par_in(par_in), .par_valid(par_valid),
        .par_ready(par_ready_2), .ser_hold(ser_hold), .ser_out(ser_out_2),
        .ser_en(ser_en_2), .ser_last(ser_last_2), .busy(busy_2));
    sipo_shift #(.WIDTH(8)) u_sipo2 (
        .clk(clk), .rst_n(rst_n), .en(ser_en_2), .ser_in(ser_out_2), .sipo_out(sipo_2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status vectors are {ser_en, ser_out, ser_last, busy, par_ready}.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        par_valid = 1'b0;
        ser_hold  = 1'b0;
        par_in    = 8'h00;
        rst_n     = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        par_valid = 1'b0;
        ser_hold  = 1'b0;
        par_in    = 8'h00;
        #2;
        checks++;
        if ({st0, st1, st2} !== {5'b00001, 5'b00001, 5'b00001}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {st0, st1, st2}, 15'b000010000100001);
        end
        checks++;
        if ({sipo_0, sipo_1, sipo_2} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_sipo: got %h expected 000000", {sipo_0, sipo_1, sipo_2});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'hA5;
        do_reset();
        par_in    = w;
        par_valid = 1'b1;
        #1;
        checks++;
        if (par_ready_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_idle_ready: got %b expected 1", par_ready_0);
        end
        tick();
        par_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            exp = {1'b1, w[i-1], (i == 8), 1'b1, (i == 8)};
            checks++;
            if (st0 !== exp) begin
                errors++;
                $display("[TB] FAIL single_cycle%0d: got %b expected %b", i, st0, exp);
            end
            tick();
        end
        #1;
        checks++;
        if ({sipo_0, busy_0, ser_en_0} !== {w, 2'b00}) begin
            errors++;
            $display("[TB] FAIL single_end: got %h/%b%b expected %h/00", sipo_0, busy_0, ser_en_0, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic       bitv;
        logic       last;
        logic [4:0] exp;
        a = 8'h3C;
        b = 8'hC3;
        do_reset();
        par_in    = a;
        par_valid = 1'b1;
        tick();
        par_in = b;
        for (int i = 1; i <= 16; i++) begin
            if (i == 9)
                par_valid = 1'b0;
            #1;
            bitv = (i <= 8) ? a[i-1] : b[i-9];
            last = (i == 8) || (i == 16);
            exp  = {1'b1, bitv, last, 1'b1, last};
            checks++;
            if (st0 !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", i, st0, exp);
            end
            if (i == 9) begin
                checks++;
                if (sipo_0 !== a) begin
                    errors++;
                    $display("[TB] FAIL b2b_first_word: got %h expected %h", sipo_0, a);
                end
            end
            tick();
        end
        #1;
        checks++;
        if ({sipo_0, busy_0} !== {b, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_second_word: got %h/%b expected %h/0", sipo_0, busy_0, b);
        end
    endtask

    task automatic test_gap();
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] exp;
        logic [4:0] mask;
        a = 8'h96;
        b = 8'h69;
        do_reset();
        par_in    = a;
        par_valid = 1'b1;
        tick();
        par_in = b;
        for (int i = 1; i <= 19; i++) begin
            if (i == 12)
                par_valid = 1'b0;
            #1;
            mask = 5'b11111;
            if (i <= 8)
                exp = {1'b1, a[i-1], (i == 8), 1'b1, 1'b0};
            else if (i <= 10)
                exp = {1'b0, a[7], 1'b0, 1'b1, 1'b0};
            else if (i == 11) begin
                exp  = 5'b00001;
                mask = 5'b10111;
            end else
                exp = {1'b1, b[i-12], (i == 19), 1'b1, 1'b0};
            checks++;
            if ((st2 & mask) !== (exp & mask)) begin
                errors++;
                $display("[TB] FAIL gap_cycle%0d: got %b expected %b (mask %b)", i, st2, exp, mask);
            end
            if (i == 9) begin
                checks++;
                if (sipo_2 !== a) begin
                    errors++;
                    $display("[TB] FAIL gap_first_word: got %h expected %h", sipo_2, a);
                end
            end
            tick();
        end
        #1;
        checks++;
        if (sipo_2 !== b) begin
            errors++;
            $display("[TB] FAIL gap_second_word: got %h expected %h", sipo_2, b);
        end
    endtask

    task automatic test_hold();
        logic [7:0] w;
        logic [4:0] exp;
        int         idx;
        w = 8'hA5;
        do_reset();
        par_in    = w;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            ser_hold = (i >= 4) && (i <= 6);
            #1;
            idx = (i < 4) ? i - 1 : ((i <= 6) ? 3 : i - 4);
            exp = {!ser_hold, w[idx], (i == 11), 1'b1, (i == 11)};
            checks++;
            if (st0 !== exp) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got %b expected %b", i, st0, exp);
            end
            tick();
        end
        ser_hold = 1'b0;
        #1;
        checks++;
        if ({sipo_0, busy_0} !== {w, 1'b0}) begin
            errors++;
            $display("[TB] FAIL hold_end: got %h/%b expected %h/0", sipo_0, busy_0, w);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        do_reset();
        par_in    = 8'h0F;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int i = 1; i <= 5; i++)
            tick();
        checks++;
        if (busy_0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy_0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (st0 !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got %b expected 00001", st0);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (st0 !== 5'b00001) begin
            errors++;
            $display("[TB] FAIL rstmid_release: got %b expected 00001", st0);
        end
        tick();
        par_in    = 8'hFF;
        par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            exp = {1'b1, 1'b1, (i == 8), 1'b1, (i == 8)};
            checks++;
            if (st0 !== exp) begin
                errors++;
                $display("[TB] FAIL rstmid_ff_cycle%0d: got %b expected %b", i, st0, exp);
            end
            tick();
        end
        #1;
        checks++;
        if (sipo_0 !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL rstmid_ff_word: got %h expected ff", sipo_0);
        end
    endtask

    task automatic test_par_in_ignore();
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] exp;
        logic [4:0] mask;
        a = 8'h11;
        b = 8'h22;
        do_reset();
        par_in    = a;
        par_valid = 1'b1;
        tick();
        for (int i = 1; i <= 18; i++) begin
            par_in = ((i == 9) || (i == 10) || (i % 2 == 1)) ? b : a;
            if (i == 11)
                par_valid = 1'b0;
            #1;
            mask = 5'b11111;
            if (i <= 8)
                exp = {1'b1, a[i-1], (i == 8), 1'b1, 1'b0};
            else if (i == 9)
                exp = {1'b0, a[7], 1'b0, 1'b1, 1'b0};
            else if (i == 10) begin
                exp  = 5'b00001;
                mask = 5'b10111;
            end else
                exp = {1'b1, b[i-11], (i == 18), 1'b1, 1'b0};
            checks++;
            if ((st1 & mask) !== (exp & mask)) begin
                errors++;
                $display("[TB] FAIL parin_cycle%0d: got %b expected %b (mask %b)", i, st1, exp, mask);
            end
            if (i == 9) begin
                checks++;
                if (sipo_1 !== a) begin
                    errors++;
                    $display("[TB] FAIL parin_first_word: got %h expected %h", sipo_1, a);
                end
            end
            tick();
        end
        #1;
        checks++;
        if ({sipo_1, ser_en_1, busy_1, par_ready_1} !== {b, 3'b010}) begin
            errors++;
            $display("[TB] FAIL parin_second_word: got %h/%b%b%b expected %h/010",
                     sipo_1, ser_en_1, busy_1, par_ready_1, b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_hold();
        test_reset_mid();
        test_par_in_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
